// File: rtl/mul_div_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Operation and state encodings plus a width-independent conditional negate.
package mul_div_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Widest value the helper handles; callers zero-extend in and truncate out.
  // Two's-complement negation of the low bits depends only on the low bits.
  localparam int unsigned NEG_MAX_W = 128;

  function automatic logic [NEG_MAX_W-1:0] cond_neg(input logic [NEG_MAX_W-1:0] v,
                                                    input logic                 neg);
    return neg ? ((~v) + NEG_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Launch/result bus between the control unit (master) and the mul/div engine (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  import mul_div_pkg::*;

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 shift-add multiplier and restoring divider sharing one
// 2*WIDTH shift register and one WIDTH+1-bit adder; results land in hi/lo.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_div_unit_if.slave     bus
);

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // |a| for multiply, |b| for divide
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // {hi part, lo part}
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  // Launch-side operand conditioning
  logic                 in_div, in_sa, in_sb;
  logic [WIDTH-1:0]     in_abs_a, in_abs_b;

  assign in_div   = bus.op[1];
  assign in_sa    = ~bus.op[0] & bus.a[WIDTH-1];
  assign in_sb    = ~bus.op[0] & bus.b[WIDTH-1];
  assign in_abs_a = WIDTH'(cond_neg(NEG_MAX_W'(bus.a), in_sa));
  assign in_abs_b = WIDTH'(cond_neg(NEG_MAX_W'(bus.b), in_sb));

  // Shared adder: multiply adds the multiplicand to the upper half when the
  // current multiplier bit is set; divide subtracts the divisor from the
  // partial remainder shifted left by one quotient bit.
  logic                 is_div;
  logic [WIDTH:0]       add_x, add_y, add_sum;
  logic                 add_cin;
  logic [2*WIDTH-1:0]   acc_step;

  assign is_div = op_q[1];

  always_comb begin
    if (is_div) begin
      add_x   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_y   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_y   = acc_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end
    add_sum = add_x + add_y + (WIDTH+1)'(add_cin);

    if (!is_div) begin
      acc_step = {add_sum, acc_q[WIDTH-1:1]};
    end else if (!add_sum[WIDTH]) begin
      acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {add_x[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction; the captured signs are zero for unsigned ops.
  logic [2*WIDTH-1:0]   fix_prod;
  logic [WIDTH-1:0]     fix_quot, fix_rem;

  assign fix_prod = (2*WIDTH)'(cond_neg(NEG_MAX_W'(acc_q), sign_a_q ^ sign_b_q));
  assign fix_quot = WIDTH'(cond_neg(NEG_MAX_W'(acc_q[WIDTH-1:0]), sign_a_q ^ sign_b_q));
  assign fix_rem  = WIDTH'(cond_neg(NEG_MAX_W'(acc_q[2*WIDTH-1:WIDTH]), sign_a_q));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          if (in_div && (bus.b == '0)) begin
            state_d    = DONE;
            hi_d       = bus.a;
            lo_d       = '1;
            div_zero_d = 1'b1;
          end else begin
            state_d  = CALC;
            op_d     = bus.op;
            sign_a_d = in_sa;
            sign_b_d = in_sb;
            cnt_d    = CNT_W'(WIDTH-1);
            opnd_d   = in_div ? in_abs_b : in_abs_a;
            acc_d    = {{WIDTH{1'b0}}, (in_div ? in_abs_a : in_abs_b)};
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (is_div) begin
          hi_d = fix_rem;
          lo_d = fix_quot;
        end else begin
          hi_d = fix_prod[2*WIDTH-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, scoreboard queue and
// hand-written back-to-back, ignored-start and mid-operation reset sequences.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    op_t         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[13];

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a falling edge; drives start for exactly one rising edge.
  task automatic launch(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Edges are counted including the start-sampling edge. Optionally fires a
  // spurious start (different operands) while the operation is in flight.
  task automatic wait_done(input int exp_lat, input int exp_busy, input int inject_at,
                           input string tag);
    int   edges = 1;
    int   busy_cycles = 0;
    bit   timeout = 1'b0;
    exp_t e;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (edges >= 200) begin
        timeout = 1'b1;
        break;
      end
      bus.start = (edges == inject_at);
      if (edges == inject_at) begin
        bus.op = DIVU;
        bus.a  = 32'd9;
        bus.b  = 32'd3;
      end
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
    if (timeout) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no done after %0d edges", tag, edges);
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    check({tag, "_busy_with_done"}, 64'(bus.busy), 64'(0));
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
      check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
    end
  endtask

  initial begin
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[8]  = '{MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    bus.start = 1'b0;
    bus.op    = MULT;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_div_zero", 64'(bus.div_zero), 64'(0));
    check("reset_hi", 64'(bus.hi), 64'(0));
    check("reset_lo", 64'(bus.lo), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      wait_done(vecs[i].dz ? 1 : 34, vecs[i].dz ? 0 : 33, -1, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'(0));
      check($sformatf("vec%0d_hold_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_idle_busy", i), 64'(bus.busy), 64'(0));
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    launch(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done(34, 33, -1, "b2b_first");
    launch(DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    wait_done(34, 33, -1, "b2b_second");
    @(negedge clk);

    // Start with different operands mid-CALC is ignored.
    launch(MULTU, 32'd1000, 32'd3, 32'd0, 32'd3000, 1'b0);
    wait_done(34, 33, 6, "ignore_start");
    @(negedge clk);
    check("ignore_start_no_relaunch", 64'(bus.busy), 64'(0));

    // Asynchronous reset mid-CALC clears everything without a clock edge.
    launch(MULT, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(bus.busy), 64'(0));
    check("midreset_done", 64'(bus.done), 64'(0));
    check("midreset_hi", 64'(bus.hi), 64'(0));
    check("midreset_lo", 64'(bus.lo), 64'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    check("midreset_no_done", 64'(bus.done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    launch(MULT, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    wait_done(34, 33, -1, "post_reset");

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit serving the HI/LO path of the multicycle CPU datapath, replacing the separate fixed-width multiplier and divider with one shared engine. It computes signed and unsigned multiplication (shift-add, radix-2) and signed and unsigned division (restoring), selected per operation. The control unit launches an operation with a start pulse and waits for a one-cycle done pulse. The results land in hi/lo, and HI/LO writeback needs no separate mux.

## Interface
- WIDTH, 32, operand width; even, ≥ 4
- CNT_W, $clog2(WIDTH), width of the iteration counter
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only when busy = 0
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; hi/lo are valid from this cycle on
- div_zero  out  1  one-cycle pulse coincident with done on a DIV/DIVU with b = 0
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient

## Operation
- FSM states:
  - IDLE: wait for start.
  - CALC: WIDTH iterations, one per clock.
  - FIX: sign correction and result latch.
  - DONE: done = 1 for one cycle.
- IDLE/DONE → CALC on start:
  - Capture op, the sign of each operand, and |a|, |b| for signed ops (raw values for unsigned ops).
  - Set counter = WIDTH−1.
- CALC:
  - Multiply: 2·WIDTH accumulator, add-and-shift per bit of |b|.
  - Divide: restoring step per bit.
  - Counter decrements each cycle; at counter = 0 → FIX.
- FIX → DONE:
  - Multiply: negate the 2·WIDTH product if the signs differ (signed op only); hi = upper half, lo = lower half.
  - Divide: quotient truncates toward zero and is negated if the signs differ; remainder takes the dividend's sign.
- DONE → IDLE unless start is high. start in DONE is accepted, giving back-to-back operations.
- Divide by zero:
  - DIV/DIVU with b = 0 at start goes straight to DONE on the next edge; CALC and FIX are skipped.
  - Results: hi = a, lo = all ones, div_zero = 1 with done.
- Signed overflow: DIV of the most-negative value by −1 gives lo = most-negative value, hi = 0, and no flag.
- start while busy is ignored; there is no queueing, and the operands of the in-flight op stay frozen.
- hi and lo change only on the FIX→DONE edge or the divide-by-zero edge; otherwise they hold their values indefinitely.
- a, b and op matter only at the start-sampling edge.

## Timing
- Reset (reset = 0, asynchronous):
  - State → IDLE.
  - busy = 0, done = 0, div_zero = 0.
  - hi = 0, lo = 0.
  - Counter and accumulators cleared.
- Reset mid-operation aborts the op immediately: no done pulse, and hi/lo are zero.
- Normal latency: start sampled at edge k → busy high after edge k through edge k+WIDTH+1 → done high after edge k+WIDTH+2 for one cycle.
- For WIDTH = 32, done follows start by 34 edges.
- Divide-by-zero latency: done and div_zero high after edge k+1.
- busy = 1 exactly in CALC and FIX. done and busy are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mul_div_pkg holds:
  - the op_t enum (MULT, MULTU, DIV, DIVU);
  - the state_t enum (IDLE, CALC, FIX, DONE);
  - an abs/negate helper function parametrised by width.
- Single module, no sub-module. The multiply and divide iterations share one 2·WIDTH shift register and one WIDTH+1-bit adder/subtractor.

## Test plan
- MULT a = 0xFFFFFFFD (−3), b = 7 → after 34 edges: done = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, busy was 1 for 33 cycles.
- MULTU a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 2 issued as a start in the DONE cycle → lo = 3, hi = 1, done 34 edges later.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_zero = 0.
- DIVU 5 / 0 → done and div_zero after 1 edge, hi = 5, lo = 0xFFFFFFFF, busy never high.
- Mid-CALC cases:
  - A new start with different operands mid-CALC is ignored; the original result is returned.
  - reset = 0 mid-CALC makes busy/done/hi/lo zero without waiting for a clock edge.
  - After release, a MULT 2·3 gives lo = 6.
